fp_normalize_pack: RTL and testbench

//  Post-addition stage of the FP32 vector adder. Inverse of the pre-alignment path: takes the raw

---
 rtl/fp_normalize_pack.sv | 157 +++++++++++++++
 tb/tb_fp_normalize_pack.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fp_normalize_pack.sv
// Post-addition normalize / round-to-nearest-even / pack stage of the FP32 vector adder.
// Handshaked on both sides; normalization is 1 bit per cycle or LZC-based single cycle.
module fp_normalize_pack #(
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter int FAST_NORM = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     sign_i,
  input  logic [EXP_W-1:0]         exp_i,
  input  logic [MAN_W+3:0]         sig_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [EXP_W+MAN_W:0]     result_o,
  output logic                     overflow_o,
  output logic                     inexact_o
);
  localparam int SW = MAN_W + 4;
  localparam int RW = 1 + EXP_W + MAN_W;
  // Two spare bits so carry increments and the EMAX compare never wrap.
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_OUT} state_t;

  state_t          state_q, state_d;
  logic            sign_q, sign_d;
  logic [EW-1:0]   e_q, e_d;
  logic [SW-1:0]   s_q, s_d;
  logic [RW-1:0]   res_q, res_d;
  logic            ovf_q, ovf_d;
  logic            inex_q, inex_d;

  logic [EW-1:0]   e_in, lz, sh;
  logic [SW-1:0]   s_sh;
  logic [EW-1:0]   e_sh;

  function automatic logic [EW-1:0] lzc(input logic [SW-2:0] v);
    logic [EW-1:0] n;
    n = EW'(SW - 1);
    for (int i = 0; i < SW - 1; i++) begin
      if (v[i]) n = EW'(SW - 2 - i);
    end
    return n;
  endfunction

  // Returns {overflow, inexact, packed word}. A result whose integer bit is
  // still clear is subnormal (or zero) and packs with exponent 0.
  function automatic logic [RW+1:0] rne_round(input logic sgn, input logic [EW-1:0] e,
                                               input logic [SW-1:0] s);
    logic                up;
    logic [MAN_W+1:0]    m;
    logic [EW-1:0]       er;
    logic                ovf;
    logic                inex;
    logic [EXP_W-1:0]    ex;
    up   = s[1] & (s[0] | s[2]);
    m    = {1'b0, s[SW-2:2]} + (MAN_W+2)'(up);
    er   = e;
    if (m[MAN_W+1]) begin
      m  = m >> 1;
      er = er + EW'(1);
    end
    ovf  = m[MAN_W] && (er >= EMAX);
    inex = s[1] | s[0] | ovf;
    ex   = m[MAN_W] ? er[EXP_W-1:0] : '0;
    if (ovf) return {1'b1, 1'b1, sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    return {ovf, inex, sgn, ex, m[MAN_W-1:0]};
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      e_q     <= '0;
      s_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      inex_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      e_q     <= e_d;
      s_q     <= s_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      inex_q  <= inex_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    e_d     = e_q;
    s_d     = s_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    inex_d  = inex_q;
    e_in    = (exp_i == '0) ? EW'(1) : EW'(exp_i);
    lz      = lzc(s_q[SW-2:0]);
    sh      = (lz < e_q - EW'(1)) ? lz : e_q - EW'(1);
    s_sh    = s_q << 1;
    e_sh    = e_q - EW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          sign_d = sign_i;
          e_d    = e_in;
          s_d    = sig_i;
          if (sig_i == '0) begin
            sign_d  = 1'b0;
            state_d = S_ROUND;
          end else if (sig_i[SW-1]) begin
            // Bit shifted out on the carry path folds into sticky.
            s_d     = {1'b0, sig_i[SW-1:2], sig_i[1] | sig_i[0]};
            e_d     = e_in + EW'(1);
            state_d = S_ROUND;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (FAST_NORM != 0) begin
          s_d     = s_q << sh;
          e_d     = e_q - sh;
          state_d = S_ROUND;
        end else if (!s_q[SW-2] && (e_q > EW'(1))) begin
          s_d = s_sh;
          e_d = e_sh;
          if (s_sh[SW-2] || (e_sh <= EW'(1))) state_d = S_ROUND;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        {ovf_d, inex_d, res_d} = rne_round(sign_q, e_q, s_q);
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_OUT);
  assign result_o    = res_q;
  assign overflow_o  = ovf_q;
  assign inexact_o   = inex_q;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed bench for fp_normalize_pack (FP32, iterative normalization).
module tb_fp_normalize_pack;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [7:0]  expv;
  logic [26:0] sig;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        inex;

  int checks   = 0;
  int failures = 0;

  fp_normalize_pack #(.EXP_W(8), .MAN_W(23), .FAST_NORM(0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .sign_i(sign), .exp_i(expv), .sig_i(sig),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .overflow_o(ovf), .inexact_o(inex)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [7:0]  ex;
    logic [26:0] sg;
    logic [31:0] res;
    logic        ovf;
    logic        inex;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Drives one bundle, measures accept-to-valid latency, compares, then handshakes.
  task automatic run(input vec_t v);
    int lat;
    @(negedge clk);
    chk({v.name, " in_ready"}, 64'(in_ready), 64'd1);
    sign = v.sgn; expv = v.ex; sig = v.sg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({v.name, " out_valid"}, 64'(out_valid), 64'd1);
    chk({v.name, " result"}, 64'(result), 64'(v.res));
    chk({v.name, " overflow"}, 64'(ovf), 64'(v.ovf));
    chk({v.name, " inexact"}, 64'(inex), 64'(v.inex));
    chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({v.name, " valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{"two",        1'b0, 8'h7F, 27'h4000000, 32'h40000000, 1'b0, 1'b0, 2};
    vecs[1]  = '{"half",       1'b0, 8'h80, 27'h0800000, 32'h3F000000, 1'b0, 1'b0, 4};
    vecs[2]  = '{"zero",       1'b1, 8'h90, 27'h0000000, 32'h00000000, 1'b0, 1'b0, 2};
    vecs[3]  = '{"tie_even",   1'b0, 8'h7F, 27'h2000002, 32'h3F800000, 1'b0, 1'b1, 3};
    vecs[4]  = '{"tie_odd",    1'b0, 8'h7F, 27'h2000006, 32'h3F800002, 1'b0, 1'b1, 3};
    vecs[5]  = '{"ovf_carry",  1'b0, 8'hFE, 27'h4000000, 32'h7F800000, 1'b1, 1'b1, 2};
    vecs[6]  = '{"min_sub",    1'b0, 8'h00, 27'h0000004, 32'h00000001, 1'b0, 1'b0, 3};
    vecs[7]  = '{"neg_one",    1'b1, 8'h7F, 27'h2000000, 32'hBF800000, 1'b0, 1'b0, 3};
    vecs[8]  = '{"rnd_carry",  1'b0, 8'h7F, 27'h3FFFFFF, 32'h40000000, 1'b0, 1'b1, 3};
    vecs[9]  = '{"carry_stk",  1'b0, 8'h7F, 27'h4000001, 32'h40000000, 1'b0, 1'b1, 2};
    vecs[10] = '{"norm_floor", 1'b0, 8'h03, 27'h0000400, 32'h00000400, 1'b0, 1'b0, 4};
    vecs[11] = '{"sub_to_nrm", 1'b0, 8'h00, 27'h1FFFFFE, 32'h00800000, 1'b0, 1'b1, 3};
    vecs[12] = '{"ovf_round",  1'b0, 8'hFE, 27'h3FFFFFF, 32'h7F800000, 1'b1, 1'b1, 3};
    vecs[13] = '{"max_norm",   1'b0, 8'h80, 27'h0000001, 32'h33800000, 1'b0, 1'b0, 27};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sign = 1'b0; expv = '0; sig = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    chk("rst flags", 64'({ovf, inex}), 64'd0);

    for (int i = 0; i < 14; i++) run(vecs[i]);

    // Back-pressure: result held, input side closed, stray in_valid ignored.
    begin
      int lat;
      @(negedge clk);
      sign = 1'b0; expv = 8'h7F; sig = 27'h4000000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("bp valid", 64'(out_valid), 64'd1);
      sign = 1'b1; expv = 8'h10; sig = 27'h0000123; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        chk("bp hold_valid", 64'(out_valid), 64'd1);
        chk("bp hold_result", 64'(result), 64'h40000000);
        chk("bp in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp release_valid", 64'(out_valid), 64'd0);
      chk("bp release_ready", 64'(in_ready), 64'd1);
    end

    // Reset in the middle of a long normalization discards the bundle.
    @(negedge clk);
    sign = 1'b0; expv = 8'h80; sig = 27'h0000001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst in_ready", 64'(in_ready), 64'd1);
    chk("midrst result", 64'(result), 64'd0);
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) chk("midrst stray_valid", 64'(out_valid), 64'd0);
    end
    run(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
